// File: rtl/match_event_logger_if.sv
// Event stream from the match logger: timestamped entries handed over with valid/ready.
// The master holds evt_ts stable while evt_valid=1 and evt_ready=0.
interface match_event_logger_if #(
  parameter int TS_W = 16
) ();
  logic            evt_valid;
  logic            evt_ready;
  logic [TS_W-1:0] evt_ts;

  modport master (output evt_valid, output evt_ts, input evt_ready);
  modport slave  (input evt_valid, input evt_ts, output evt_ready);
endinterface

// File: rtl/match_event_logger.sv
// Timestamps rising edges of match_in into a first-word-fall-through FIFO, with saturating match/drop stats.
// An event at one edge is visible on evt_valid after that edge; a full FIFO with no pop drops the event.
module match_event_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     match_in,
  input  logic                     clr_stats,
  match_event_logger_if.master     evt,
  output logic [$clog2(DEPTH):0]   fifo_lvl,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [TS_W-1:0] ts;
  logic            match_q;
  logic [TS_W-1:0] mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [LW-1:0]   lvl;

  logic event_hit;
  logic pop;
  logic full;
  logic push;
  logic drop;

  assign event_hit = en & match_in & ~match_q;
  assign pop       = evt.evt_valid & evt.evt_ready;
  assign full      = (lvl == LW'(DEPTH));
  // A pop frees a slot in the same cycle, so a full FIFO being drained still accepts.
  assign push      = event_hit & (~full | pop);
  assign drop      = event_hit & ~push;

  assign evt.evt_valid = (lvl != '0);
  assign evt.evt_ts    = evt.evt_valid ? mem[rd_ptr] : '0;
  assign fifo_lvl      = lvl;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= ts;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts        <= '0;
      match_q   <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      lvl       <= '0;
      match_cnt <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      match_q <= match_in;
      if (en) begin
        ts <= ts + TS_W'(1);
      end

      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   lvl <= lvl + LW'(1);
        2'b01:   lvl <= lvl - LW'(1);
        default: lvl <= lvl;
      endcase

      // Clearing still counts an event that lands in the same cycle.
      if (clr_stats) begin
        match_cnt <= event_hit ? CNT_W'(1) : '0;
        drop_cnt  <= drop ? CNT_W'(1) : '0;
        overflow  <= drop;
      end else begin
        if (event_hit && (match_cnt != '1)) begin
          match_cnt <= match_cnt + CNT_W'(1);
        end
        if (drop && (drop_cnt != '1)) begin
          drop_cnt <= drop_cnt + CNT_W'(1);
        end
        if (drop) begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule
